// File: rtl/acc_cpu_pkg.sv
// ---------------------------------------------------------------------------
// acc_cpu_pkg : shared widths, opcodes, ALU codes and sequencer states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package acc_cpu_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDAC  = 4'h1;
    localparam logic [3:0] OP_STAC  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_DECAC = 4'h5;
    localparam logic [3:0] OP_SHR2  = 4'h6;
    localparam logic [3:0] OP_SHR3  = 4'h7;
    localparam logic [3:0] OP_SHR4  = 4'h8;
    localparam logic [3:0] OP_MVACR = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JMPZ  = 4'hB;
    localparam logic [3:0] OP_JMPNZ = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_NOP    = 3'd0;
    localparam logic [2:0] ALU_DECAC  = 3'd1;
    localparam logic [2:0] ALU_SHIFT4 = 3'd2;
    localparam logic [2:0] ALU_SHIFT3 = 3'd3;
    localparam logic [2:0] ALU_SHIFT2 = 3'd4;
    localparam logic [2:0] ALU_ADD    = 3'd5;
    localparam logic [2:0] ALU_SUB    = 3'd6;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        ALU_WB = 3'd3,
        MEM    = 3'd4,
        HALT   = 3'd5
    } state_t;

    function automatic logic [2:0] alu_map(input logic [3:0] opcode);
        case (opcode)
            OP_ADD:   alu_map = ALU_ADD;
            OP_SUB:   alu_map = ALU_SUB;
            OP_DECAC: alu_map = ALU_DECAC;
            OP_SHR2:  alu_map = ALU_SHIFT2;
            OP_SHR3:  alu_map = ALU_SHIFT3;
            OP_SHR4:  alu_map = ALU_SHIFT4;
            default:  alu_map = ALU_NOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_control_unit.sv
// ---------------------------------------------------------------------------
// acc_control_unit : multicycle fetch/decode/execute sequencer, owns PC/IR/Z
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module acc_control_unit #(
    parameter int                ADDR_W   = acc_cpu_pkg::ADDR_W,
    parameter int                DATA_W   = acc_cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        alu_op,
    input  logic              alu_z,
    output logic              ac_load,
    output logic              ac_src,
    output logic              r_load,
    output logic              halted,
    output logic              illegal
);
    import acc_cpu_pkg::*;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
    logic [DATA_W-1:0]   r_ir, w_ir_nxt;
    logic                r_z, w_z_nxt;
    logic [3:0]          w_opcode;
    logic [ADDR_W-1:0]   w_operand;

    assign w_opcode  = r_ir[DATA_W-1 -: 4];
    assign w_operand = r_ir[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_z     <= w_z_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_z_nxt     = r_z;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        alu_op      = ALU_NOP;
        ac_load     = 1'b0;
        ac_src      = 1'b0;
        r_load      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;

        case (r_state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ack) begin
                    w_ir_nxt    = mem_rdata;
                    w_pc_nxt    = r_pc + 1'b1;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                w_state_nxt = FETCH;
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_DECAC,
                    OP_SHR2, OP_SHR3, OP_SHR4: w_state_nxt = EXEC;
                    OP_LDAC, OP_STAC:          w_state_nxt = MEM;
                    OP_MVACR:                  r_load = 1'b1;
                    OP_JMP:                    w_pc_nxt = w_operand;
                    OP_JMPZ:  if (r_z)         w_pc_nxt = w_operand;
                    OP_JMPNZ: if (!r_z)        w_pc_nxt = w_operand;
                    OP_HALT:                   w_state_nxt = HALT;
                    OP_NOP:                    w_state_nxt = FETCH;
                    default:                   illegal = 1'b1;
                endcase
            end
            EXEC: begin
                alu_op      = alu_map(w_opcode);
                w_state_nxt = ALU_WB;
            end
            ALU_WB: begin
                alu_op      = alu_map(w_opcode);
                ac_load     = 1'b1;
                w_z_nxt     = alu_z;
                w_state_nxt = FETCH;
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_addr = w_operand;
                mem_we   = (w_opcode == OP_STAC);
                if (mem_ack) begin
                    ac_load     = (w_opcode == OP_LDAC);
                    ac_src      = (w_opcode == OP_LDAC);
                    w_state_nxt = FETCH;
                end
            end
            HALT: halted = 1'b1;
            default: w_state_nxt = FETCH;
        endcase

        // The registered state resets to FETCH, so outputs are forced quiet while reset is held.
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            mem_addr = '0;
            alu_op   = ALU_NOP;
            ac_load  = 1'b0;
            ac_src   = 1'b0;
            r_load   = 1'b0;
            halted   = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

`default_nettype wire
